// File: rtl/flood_pkg.sv
// Shared constants, FSM encoding and LFSR step function for the Flood-It board engine.
package flood_pkg;

  localparam int unsigned DefMaxSize  = 26;
  localparam int unsigned DefColorW   = 3;
  localparam logic [15:0] DefLfsrSeed = 16'hACE1;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StMove,
    StGrow,
    StReady,
    StDone
  } state_e;

  // Fibonacci LFSR, taps 16,14,13,11 (bit indices 15,13,12,10).
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with load-on-reset seed and step enable.
module lfsr16
  import flood_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [15:0] i_seed,
  output logic [15:0] o_state
);

  logic [15:0] r_state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= i_seed;
    end else if (i_en) begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/flood_engine.sv
// Flood-It board store: random fill, raster-pass flood growth, display read port and win flag.
module flood_engine
  import flood_pkg::*;
#(
  parameter int unsigned MAX_SIZE  = DefMaxSize,
  parameter int unsigned COLOR_W   = DefColorW,
  parameter logic [15:0] LFSR_SEED = DefLfsrSeed
) (
  input  logic               MASTER_CLOCK,
  input  logic               RESET,
  input  logic               INITIALIZE_BOARD,
  input  logic [4:0]         final_SIZE,
  input  logic [3:0]         final_COLOR_NUM,
  input  logic               COLOR_SEL_SIG,
  input  logic [COLOR_W-1:0] COLOR_SELECTED,
  output logic               BOARD_READY,
  output logic               CURRENTLY_CHANGING_COLOR,
  input  logic [4:0]         RD_ROW,
  input  logic [4:0]         RD_COL,
  output logic [COLOR_W-1:0] RD_COLOR,
  output logic               RD_OWNED,
  output logic               WON
);

  localparam int unsigned NCell = MAX_SIZE * MAX_SIZE;
  localparam int unsigned IdxW  = $clog2(NCell);

  state_e r_state, w_state_d;

  logic [4:0]                     r_row, r_col, r_size;
  logic [3:0]                     r_cnum;
  logic [COLOR_W-1:0]             r_target, r_sel;
  logic                           r_valid, r_init_grow, r_changed, r_changing;
  logic [9:0]                     r_count;
  logic [NCell-1:0][COLOR_W-1:0]  r_color;
  logic [NCell-1:0]               r_owned;
  logic [COLOR_W-1:0]             r_rd_color;
  logic                           r_rd_owned;

  logic [15:0]                    w_lfsr;
  logic                           w_unused_lfsr;
  logic [IdxW-1:0]                w_idx, w_up, w_dn, w_lf, w_rt, w_rd_idx;
  logic                           w_last, w_rand_ok, w_noop, w_nb_owned, w_grab, w_any_change;
  logic                           w_rd_in;
  logic [9:0]                     w_area;
  logic [NCell-1:0][COLOR_W-1:0]  w_recolor;

  lfsr16 u_lfsr (
    .i_clk   (MASTER_CLOCK),
    .i_rst   (RESET),
    .i_en    (r_state == StFill),
    .i_seed  (LFSR_SEED),
    .o_state (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr[15:3];

  assign w_idx     = IdxW'(r_row) * IdxW'(MAX_SIZE) + IdxW'(r_col);
  assign w_last    = (r_row == r_size - 5'd1) && (r_col == r_size - 5'd1);
  assign w_rand_ok = {1'b0, w_lfsr[2:0]} < r_cnum;
  assign w_noop    = (int'(r_sel) >= int'(r_cnum)) || (r_sel == r_color[0]);

  // Neighbour indices fall back to the cell itself at the board edge; the guard masks them.
  assign w_up = (r_row != 5'd0) ? w_idx - IdxW'(MAX_SIZE) : w_idx;
  assign w_dn = (r_row < r_size - 5'd1) ? w_idx + IdxW'(MAX_SIZE) : w_idx;
  assign w_lf = (r_col != 5'd0) ? w_idx - IdxW'(1) : w_idx;
  assign w_rt = (r_col < r_size - 5'd1) ? w_idx + IdxW'(1) : w_idx;

  assign w_nb_owned = ((r_row != 5'd0) && r_owned[w_up]) ||
                      ((r_row < r_size - 5'd1) && r_owned[w_dn]) ||
                      ((r_col != 5'd0) && r_owned[w_lf]) ||
                      ((r_col < r_size - 5'd1) && r_owned[w_rt]);

  assign w_grab       = (r_state == StGrow) && !r_owned[w_idx] &&
                        (r_color[w_idx] == r_target) && w_nb_owned;
  assign w_any_change = r_changed || w_grab;

  always_comb begin
    w_recolor = r_color;
    for (int i = 0; i < NCell; i++) begin
      if (r_owned[i]) w_recolor[i] = r_sel;
    end
  end

  always_ff @(posedge MASTER_CLOCK) begin
    if (RESET) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (INITIALIZE_BOARD)             w_state_d = StFill;
        else if (COLOR_SEL_SIG && r_valid) w_state_d = StMove;
      end
      StFill:  if (w_rand_ok && w_last) w_state_d = StGrow;
      StMove:  w_state_d = w_noop ? StDone : StGrow;
      StGrow: begin
        if (w_last && !w_any_change) w_state_d = r_init_grow ? StReady : StDone;
      end
      StReady: w_state_d = StIdle;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge MASTER_CLOCK) begin
    if (RESET) begin
      r_row       <= '0;
      r_col       <= '0;
      r_size      <= '0;
      r_cnum      <= '0;
      r_target    <= '0;
      r_sel       <= '0;
      r_valid     <= 1'b0;
      r_init_grow <= 1'b0;
      r_changed   <= 1'b0;
      r_changing  <= 1'b0;
      r_count     <= '0;
      r_color     <= '0;
      r_owned     <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (INITIALIZE_BOARD) begin
            r_size  <= final_SIZE;
            r_cnum  <= final_COLOR_NUM;
            r_row   <= '0;
            r_col   <= '0;
            r_valid <= 1'b0;
          end else if (COLOR_SEL_SIG && r_valid) begin
            r_sel      <= COLOR_SELECTED;
            r_changing <= 1'b1;
          end
        end
        StFill: begin
          if (w_rand_ok) begin
            r_color[w_idx] <= COLOR_W'(w_lfsr[2:0]);
            if (w_last) begin
              r_owned     <= NCell'(1);
              r_target    <= r_color[0];
              r_count     <= 10'd1;
              r_init_grow <= 1'b1;
              r_changed   <= 1'b0;
            end
          end
        end
        StMove: begin
          if (!w_noop) begin
            r_color     <= w_recolor;
            r_target    <= r_sel;
            r_row       <= '0;
            r_col       <= '0;
            r_changed   <= 1'b0;
            r_init_grow <= 1'b0;
          end
        end
        StGrow: begin
          if (w_grab) begin
            r_owned[w_idx] <= 1'b1;
            r_count        <= r_count + 10'd1;
            r_changed      <= 1'b1;
          end
          if (w_last) r_changed <= 1'b0;
        end
        StReady: r_valid    <= 1'b1;
        StDone:  r_changing <= 1'b0;
        default: ;
      endcase
      // Raster counters step on every fill write and every grow cycle, wrapping at SIZE-1.
      if ((r_state == StFill && w_rand_ok) || r_state == StGrow) begin
        if (r_col == r_size - 5'd1) begin
          r_col <= '0;
          r_row <= (r_row == r_size - 5'd1) ? 5'd0 : r_row + 5'd1;
        end else begin
          r_col <= r_col + 5'd1;
        end
      end
    end
  end

  assign w_rd_in  = (RD_ROW < r_size) && (RD_COL < r_size);
  assign w_rd_idx = w_rd_in ? IdxW'(RD_ROW) * IdxW'(MAX_SIZE) + IdxW'(RD_COL) : '0;

  always_ff @(posedge MASTER_CLOCK) begin
    if (RESET) begin
      r_rd_color <= '0;
      r_rd_owned <= 1'b0;
    end else begin
      r_rd_color <= w_rd_in ? r_color[w_rd_idx] : '0;
      r_rd_owned <= w_rd_in && r_owned[w_rd_idx];
    end
  end

  assign w_area = 10'(r_size) * 10'(r_size);

  assign BOARD_READY              = (r_state == StReady);
  assign CURRENTLY_CHANGING_COLOR = r_changing;
  assign RD_COLOR                 = r_rd_color;
  assign RD_OWNED                 = r_rd_owned;
  assign WON                      = r_valid && (r_count == w_area);

endmodule

// File: tb/tb_flood_engine.sv
// Directed bench for flood_engine: LFSR/BFS reference model, read-port scoreboard queues.
module tb_flood_engine;

  logic       clk = 1'b0;
  logic       rst, init, sel_sig;
  logic [4:0] fsize, rd_row, rd_col;
  logic [3:0] fcnum;
  logic [2:0] csel, rd_color;
  logic       ready, changing, rd_own, won;

  flood_engine dut (
    .MASTER_CLOCK             (clk),
    .RESET                    (rst),
    .INITIALIZE_BOARD         (init),
    .final_SIZE               (fsize),
    .final_COLOR_NUM          (fcnum),
    .COLOR_SEL_SIG            (sel_sig),
    .COLOR_SELECTED           (csel),
    .BOARD_READY              (ready),
    .CURRENTLY_CHANGING_COLOR (changing),
    .RD_ROW                   (rd_row),
    .RD_COL                   (rd_col),
    .RD_COLOR                 (rd_color),
    .RD_OWNED                 (rd_own),
    .WON                      (won)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [2:0]  m_col [26][26];
  bit          m_own [26][26];
  int          m_size, m_cnum;
  bit          m_valid;
  logic [15:0] m_lfsr;

  logic [2:0] q_col [$];
  bit         q_own [$];
  bit         q_in  [$];
  int         q_cnum [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_lfsr  = 16'hACE1;
    m_size  = 0;
    m_cnum  = 0;
    m_valid = 0;
    for (int r = 0; r < 26; r++)
      for (int c = 0; c < 26; c++) begin
        m_col[r][c] = 3'd0;
        m_own[r][c] = 1'b0;
      end
  endtask

  task automatic model_fill();
    logic [2:0] v;
    bit done;
    for (int r = 0; r < m_size; r++)
      for (int c = 0; c < m_size; c++) begin
        done = 0;
        while (!done) begin
          v      = m_lfsr[2:0];
          m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
          if (int'(v) < m_cnum) begin
            m_col[r][c] = v;
            done = 1;
          end
        end
      end
  endtask

  function automatic bit nb_owned(input bit o[26][26], input int r, input int c);
    return (r > 0 && o[r-1][c]) || (r < m_size - 1 && o[r+1][c]) ||
           (c > 0 && o[r][c-1]) || (c < m_size - 1 && o[r][c+1]);
  endfunction

  // Number of raster passes the grow phase takes, final no-change pass included.
  function automatic int model_passes(input logic [2:0] tgt);
    bit o[26][26];
    bit chg;
    int p = 0;
    o = m_own;
    do begin
      chg = 0;
      p++;
      for (int r = 0; r < m_size; r++)
        for (int c = 0; c < m_size; c++)
          if (!o[r][c] && m_col[r][c] == tgt && nb_owned(o, r, c)) begin
            o[r][c] = 1'b1;
            chg = 1;
          end
    end while (chg);
    return p;
  endfunction

  task automatic model_bfs(input logic [2:0] tgt);
    int q[$];
    int dr[4] = '{-1, 1, 0, 0};
    int dc[4] = '{0, 0, -1, 1};
    int idx, r, c, nr, nc;
    for (int i = 0; i < 26; i++)
      for (int j = 0; j < 26; j++) m_own[i][j] = 1'b0;
    m_own[0][0] = 1'b1;
    q.push_back(0);
    while (q.size() > 0) begin
      idx = q.pop_front();
      r = idx / 26;
      c = idx % 26;
      for (int d = 0; d < 4; d++) begin
        nr = r + dr[d];
        nc = c + dc[d];
        if (nr >= 0 && nr < m_size && nc >= 0 && nc < m_size)
          if (!m_own[nr][nc] && m_col[nr][nc] == tgt) begin
            m_own[nr][nc] = 1'b1;
            q.push_back(nr * 26 + nc);
          end
      end
    end
  endtask

  function automatic bit model_won();
    if (!m_valid) return 0;
    for (int r = 0; r < m_size; r++)
      for (int c = 0; c < m_size; c++)
        if (!m_own[r][c]) return 0;
    return 1;
  endfunction

  function automatic logic [2:0] pick_move();
    for (int r = 0; r < m_size; r++)
      for (int c = 0; c < m_size; c++) begin
        bit a = (r > 0 && m_own[r-1][c]) || (r < m_size - 1 && m_own[r+1][c]) ||
                (c > 0 && m_own[r][c-1]) || (c < m_size - 1 && m_own[r][c+1]);
        if (!m_own[r][c] && a) return m_col[r][c];
      end
    return m_col[0][0];
  endfunction

  task automatic pop_check();
    bit in_b;
    int cn;
    in_b = q_in.pop_front();
    cn   = q_cnum.pop_front();
    check("rd_color", rd_color, q_col.pop_front());
    check("rd_owned", rd_own, q_own.pop_front());
    if (in_b) check("rd_range", int'(rd_color) < cn, 1);
  endtask

  // Sweep the whole address space including out-of-board rows/columns.
  task automatic sweep();
    bit in_b;
    for (int r = 0; r < 27; r++)
      for (int c = 0; c < 27; c++) begin
        @(posedge clk); #1;
        if (q_col.size() > 0) pop_check();
        rd_row = 5'(r);
        rd_col = 5'(c);
        in_b = (r < m_size) && (c < m_size);
        q_in.push_back(in_b);
        q_cnum.push_back(m_cnum);
        q_col.push_back(in_b ? m_col[r][c] : 3'd0);
        q_own.push_back(in_b ? m_own[r][c] : 1'b0);
      end
    @(posedge clk); #1;
    pop_check();
    check("won", won, model_won());
  endtask

  task automatic wait_ready(input int sz, input int cn);
    int pulses = 0;
    bit got = 0;
    fsize = 5'(sz);
    fcnum = 4'(cn);
    init  = 1'b1;
    for (int k = 0; k < 20000 && !got; k++) begin
      @(posedge clk); #1;
      if (ready) begin
        pulses++;
        got = 1;
      end
    end
    init = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready) pulses++;
    end
    check("ready_pulses", pulses, 1);
    m_size  = sz;
    m_cnum  = cn;
    m_valid = 0;
    model_fill();
    model_bfs(m_col[0][0]);
    m_valid = 1;
  endtask

  task automatic do_move(input logic [2:0] sel, input bit init_mid, input int nsz, input int ncn);
    int exp_high, hi;
    bit seen = 0;
    if (int'(sel) >= m_cnum || sel == m_col[0][0]) begin
      exp_high = 2;
    end else begin
      for (int r = 0; r < m_size; r++)
        for (int c = 0; c < m_size; c++)
          if (m_own[r][c]) m_col[r][c] = sel;
      exp_high = 2 + model_passes(sel) * m_size * m_size;
      model_bfs(sel);
    end
    csel    = sel;
    sel_sig = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (changing) seen = 1;
    end
    sel_sig = 1'b0;
    hi = seen ? 1 : 0;
    if (seen) begin
      for (int k = 0; k < 60000; k++) begin
        if (init_mid && hi == 3) begin
          fsize = 5'(nsz);
          fcnum = 4'(ncn);
          init  = 1'b1;
        end
        @(posedge clk); #1;
        if (!changing) break;
        hi++;
      end
    end
    check("chg_cycles", hi, exp_high);
    if (init_mid) wait_ready(nsz, ncn);
  endtask

  task automatic reset_mid_grow();
    bit seen = 0;
    csel    = pick_move();
    sel_sig = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (changing) seen = 1;
    end
    sel_sig = 1'b0;
    check("rst_move_started", seen, 1);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_changing", changing, 0);
    check("rst_ready", ready, 0);
    check("rst_won", won, 0);
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; init = 1'b0; sel_sig = 1'b0;
    fsize = '0; fcnum = '0; csel = '0; rd_row = '0; rd_col = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_changing", changing, 0);
    check("reset_ready", ready, 0);
    check("reset_won", won, 0);
    check("reset_rd_color", rd_color, 0);
    rst = 1'b0;

    // Small board: fill, ownership of the corner region, then play to a win.
    wait_ready(2, 3);
    sweep();
    for (int k = 0; k < 6 && !model_won(); k++) begin
      do_move(pick_move(), 1'b0, 0, 0);
      sweep();
    end
    check("won_2x2", won, 1);

    // Full-size board: out-of-range and same-colour moves are no-ops.
    wait_ready(26, 6);
    sweep();
    do_move(3'd7, 1'b0, 0, 0);
    do_move(m_col[0][0], 1'b0, 0, 0);
    sweep();

    // Several real moves; latency depends on how many raster passes each needs.
    for (int k = 0; k < 4; k++) do_move(pick_move(), 1'b0, 0, 0);
    sweep();

    // Init request arriving mid-move waits for the move to finish.
    do_move(pick_move(), 1'b1, 6, 4);
    sweep();

    // Reset during a grow, then moves are ignored until the next board is ready.
    wait_ready(26, 5);
    reset_mid_grow();
    sweep();
    csel    = 3'd1;
    sel_sig = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check("chg_preboard", changing, 0);
    end
    sel_sig = 1'b0;
    wait_ready(2, 3);
    sweep();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
